// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the fetch queue unit.
package fetch_queue_unit_pkg;

    // Kind of control-flow redirect resolved in the current cycle.
    // JR outranks J, which outranks BR.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        BR   = 2'd1,
        J    = 2'd2,
        JR   = 2'd3
    } redir_kind_e;

    // Byte distance between sequential instruction words.
    localparam int unsigned PC_INC = 4;

    // Width of the occupancy counter for a queue of the given depth.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fetch_queue_unit_pkg

// File: rtl/fetch_queue_unit_if.sv
// Bundle of instruction-memory, decode and redirect signals around the
// fetch queue unit.
//
// Handshake semantics: the queue head is offered to decode while if_valid
// is high and is consumed in exactly the cycles where if_valid && id_ready
// are both high at the rising edge. if_valid never depends on id_ready.
// imem_req is a fire-and-forget read: the memory returns imem_rdata in the
// cycle immediately after the request, with no back-pressure.
interface fetch_queue_unit_if #(
    parameter int XLEN = 32
);
    // instruction memory
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;

    // decode side
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_pc4;
    logic            id_ready;

    // redirects
    logic [XLEN-1:0] redir_pc;
    logic            br_taken;
    logic [XLEN-1:0] br_offset;
    logic            jump;
    logic [25:0]     jump_index;
    logic            jr;
    logic [XLEN-1:0] jr_target;
    logic            misalign;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        output if_valid, if_instr, if_pc, if_pc4,
        input  id_ready,
        input  redir_pc, br_taken, br_offset, jump, jump_index, jr, jr_target,
        output misalign
    );

    // Environment side (memory, decode, execute).
    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        input  if_valid, if_instr, if_pc, if_pc4,
        output id_ready,
        output redir_pc, br_taken, br_offset, jump, jump_index, jr, jr_target,
        input  misalign
    );

endinterface : fetch_queue_unit_if

// File: rtl/fetch_queue_unit_fetch_fifo.sv
// Small circular FIFO holding {pc, instruction} entries for the fetch
// queue. Head entry is read combinationally; flush empties it in one edge.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pop only when something is stored; push when there is room, or when a
    // simultaneous pop frees the slot being written. Pointers wrap naturally
    // because DEPTH is a power of two.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign valid = (count_q != '0);
    assign count = count_q;

endmodule : fetch_fifo

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: issues sequential word reads, queues the
// returning instructions with their PCs for decode, and restarts fetch on
// branch / jump / register-jump redirects.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                clk,
    input logic                rst,
    fetch_queue_unit_if.master bus
);
    localparam int CW = count_width(QDEPTH);
    localparam int FW = XLEN + 32;

    // Upper PC bits kept by an absolute jump (the 256 MB region).
    localparam logic [XLEN-1:0] JUMP_REGION_MASK = {{(XLEN-28){1'b1}}, 28'd0};
    // Clears the byte offset of a register-jump target.
    localparam logic [XLEN-1:0] WORD_MASK        = {{(XLEN-2){1'b1}}, 2'b00};

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            misalign_q, misalign_d;

    redir_kind_e     redir_kind;
    logic [XLEN-1:0] redir_target;
    logic [XLEN-1:0] seq_pc;
    logic            redirect;

    logic [CW-1:0]   fifo_count;
    logic [CW:0]     occupancy;
    logic            fifo_valid;
    logic            fifo_push;
    logic            fifo_pop;
    logic [FW-1:0]   fifo_head;
    logic            fetch_req;

    // Resolve the highest-priority redirect and its target address.
    always_comb begin
        redir_kind   = NONE;
        redir_target = fetch_pc_q;
        seq_pc       = bus.redir_pc + XLEN'(PC_INC);
        if (bus.jr) begin
            redir_kind   = JR;
            redir_target = bus.jr_target & WORD_MASK;
        end else if (bus.jump) begin
            redir_kind   = J;
            redir_target = (seq_pc & JUMP_REGION_MASK)
                         | XLEN'({bus.jump_index, 2'b00});
        end else if (bus.br_taken) begin
            redir_kind   = BR;
            redir_target = seq_pc + (bus.br_offset << 2);
        end
    end

    assign redirect = (redir_kind != NONE);

    // Every request reserves a queue slot, so queued plus in-flight entries
    // can never exceed QDEPTH and the arriving response always has room.
    // Held off during reset so the first request appears right after release.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign fetch_req = rst && !redirect && (occupancy < (CW+1)'(QDEPTH));

    // A response arriving in a redirect cycle belongs to the old path.
    assign fifo_push = inflight_q && !redirect;
    assign fifo_pop  = fifo_valid && bus.id_ready;

    // Fetch PC, in-flight tracking and misalignment flag next-state.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = fetch_req;
        inflight_pc_d = inflight_pc_q;
        misalign_d    = (redir_kind == JR) && (bus.jr_target[1:0] != 2'b00);
        if (redirect) begin
            fetch_pc_d = redir_target;
        end else if (fetch_req) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
        end
        if (fetch_req) begin
            inflight_pc_d = fetch_pc_q;
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            misalign_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            misalign_q    <= misalign_d;
        end
    end

    fetch_fifo #(
        .W     (FW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data ({inflight_pc_q, bus.imem_rdata}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    // Head fields read as zero whenever the queue is empty.
    assign bus.imem_req  = fetch_req;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.if_valid  = fifo_valid;
    assign bus.if_pc     = fifo_valid ? fifo_head[FW-1:32] : '0;
    assign bus.if_instr  = fifo_valid ? fifo_head[31:0]    : '0;
    assign bus.if_pc4    = bus.if_pc + XLEN'(PC_INC);
    assign bus.misalign  = misalign_q;

endmodule : fetch_queue_unit

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit. Inputs change on the falling edge;
// outputs are sampled 1 ns later. The memory model returns the request
// address as the instruction word, so every entry must have instr == pc.
module tb_fetch_queue_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fetch_queue_unit_if #(.XLEN(32)) bus ();

    fetch_queue_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / memory model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_req ? bus.imem_addr : 32'hDEAD_BEEF;
    end

    // driver tasks
    task automatic clear_redirects();
        bus.redir_pc   = '0;
        bus.br_taken   = 1'b0;
        bus.br_offset  = '0;
        bus.jump       = 1'b0;
        bus.jump_index = '0;
        bus.jr         = 1'b0;
        bus.jr_target  = '0;
    endtask

    // Leaves the bench 1 ns into the first cycle after reset release.
    task automatic apply_reset(input logic ready);
        @(negedge clk);
        rst = 1'b0;
        bus.id_ready = 1'b0;
        clear_redirects();
        repeat (2) @(negedge clk);
        bus.id_ready = ready;
        rst = 1'b1;
        #1;
    endtask

    task automatic next_sample();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.id_ready = 1'b1;
        clear_redirects();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", bus.imem_req); end
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.if_valid); end
        checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign got %b want 0", bus.misalign); end
        checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", bus.if_pc); end
        checks++; if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", bus.if_instr); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rel_req got %b want 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rel_addr got %h want 0", bus.imem_addr); end
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rel_valid got %b want 0", bus.if_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        apply_reset(1'b1);
        next_sample();
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL stream_fill got %b want 0", bus.if_valid); end
        checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL stream_addr1 got %h want 4", bus.imem_addr); end
        for (int i = 0; i < 3; i++) begin
            next_sample();
            exp_pc = 32'(i * 4);
            checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid%0d got %b want 1", i, bus.if_valid); end
            checks++; if (bus.if_pc !== exp_pc) begin errors++; $display("FAIL stream_pc%0d got %h want %h", i, bus.if_pc, exp_pc); end
            checks++; if (bus.if_instr !== exp_pc) begin errors++; $display("FAIL stream_instr%0d got %h want %h", i, bus.if_instr, exp_pc); end
            checks++; if (bus.if_pc4 !== exp_pc + 32'h4) begin errors++; $display("FAIL stream_pc4_%0d got %h want %h", i, bus.if_pc4, exp_pc + 32'h4); end
        end
    endtask

    task automatic test_fill_drain();
        int          nreq;
        logic [31:0] exp_pc;
        apply_reset(1'b0);
        nreq = int'(bus.imem_req);
        for (int i = 1; i < 10; i++) begin
            next_sample();
            nreq += int'(bus.imem_req);
        end
        checks++; if (nreq != 4) begin errors++; $display("FAIL fill_reqs got %0d want 4", nreq); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL fill_req_low got %b want 0", bus.imem_req); end
        checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL fill_head got %h want 0", bus.if_pc); end
        @(negedge clk);
        bus.id_ready = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL drain_full_req got %b want 0", bus.imem_req); end
        checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL drain_pc0 got %h want 0", bus.if_pc); end
        next_sample();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin errors++; $display("FAIL drain_refetch got req %b addr %h want 1 10", bus.imem_req, bus.imem_addr); end
        for (int i = 1; i < 5; i++) begin
            if (i > 1) next_sample();
            exp_pc = 32'(i * 4);
            checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc) begin errors++; $display("FAIL drain_pc%0d got %b/%h want 1/%h", i, bus.if_valid, bus.if_pc, exp_pc); end
        end
    endtask

    task automatic test_branch();
        apply_reset(1'b1);
        repeat (4) next_sample();
        checks++; if (bus.if_pc !== 32'h8) begin errors++; $display("FAIL br_pre_pc got %h want 8", bus.if_pc); end
        bus.br_taken  = 1'b1;
        bus.redir_pc  = 32'h8;
        bus.br_offset = 32'd3;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL br_req_block got %b want 0", bus.imem_req); end
        @(negedge clk);
        clear_redirects();
        #1;
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL br_flush got %b want 0", bus.if_valid); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h18) begin errors++; $display("FAIL br_target got req %b addr %h want 1 18", bus.imem_req, bus.imem_addr); end
        next_sample();
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL br_stale got %b pc %h want 0", bus.if_valid, bus.if_pc); end
        next_sample();
        checks++; if (bus.if_pc !== 32'h18 || bus.if_instr !== 32'h18) begin errors++; $display("FAIL br_new_pc got %h/%h want 18/18", bus.if_pc, bus.if_instr); end
        next_sample();
        checks++; if (bus.if_pc !== 32'h1C) begin errors++; $display("FAIL br_next_pc got %h want 1c", bus.if_pc); end
    endtask

    task automatic test_jr_priority();
        apply_reset(1'b1);
        repeat (3) next_sample();
        bus.jr         = 1'b1;
        bus.jr_target  = 32'h103;
        bus.jump       = 1'b1;
        bus.jump_index = 26'h3FF;
        bus.br_taken   = 1'b1;
        bus.redir_pc   = 32'h20;
        bus.br_offset  = 32'd1;
        #1;
        checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL jr_misalign_early got %b want 0", bus.misalign); end
        @(negedge clk);
        clear_redirects();
        #1;
        checks++; if (bus.misalign !== 1'b1) begin errors++; $display("FAIL jr_misalign got %b want 1", bus.misalign); end
        checks++; if (bus.imem_addr !== 32'h100 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL jr_target got req %b addr %h want 1 100", bus.imem_req, bus.imem_addr); end
        next_sample();
        checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL jr_pulse_once got %b want 0", bus.misalign); end
        next_sample();
        checks++; if (bus.if_pc !== 32'h100) begin errors++; $display("FAIL jr_pc got %h want 100", bus.if_pc); end
    endtask

    task automatic test_jump();
        apply_reset(1'b1);
        repeat (2) next_sample();
        bus.jump       = 1'b1;
        bus.redir_pc   = 32'h4000_0010;
        bus.jump_index = 26'h10;
        bus.br_taken   = 1'b1;
        bus.br_offset  = 32'd5;
        @(negedge clk);
        clear_redirects();
        #1;
        checks++; if (bus.imem_addr !== 32'h4000_0040) begin errors++; $display("FAIL j_addr got %h want 40000040", bus.imem_addr); end
        repeat (2) next_sample();
        checks++; if (bus.if_pc !== 32'h4000_0040) begin errors++; $display("FAIL j_pc got %h want 40000040", bus.if_pc); end
        checks++; if (bus.if_pc4 !== 32'h4000_0044) begin errors++; $display("FAIL j_pc4 got %h want 40000044", bus.if_pc4); end
    endtask

    task automatic test_mid_reset();
        apply_reset(1'b0);
        repeat (4) next_sample();
        checks++; if (bus.if_valid !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL mr_pre got valid %b req %b want 1 0", bus.if_valid, bus.imem_req); end
        rst = 1'b0;
        #1;
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b want 0", bus.if_valid); end
        checks++; if (bus.if_pc !== 32'h0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL mr_outputs got pc %h req %b want 0 0", bus.if_pc, bus.imem_req); end
        repeat (2) @(negedge clk);
        bus.id_ready = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL mr_restart got req %b addr %h want 1 0", bus.imem_req, bus.imem_addr); end
        next_sample();
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL mr_stale got %b want 0", bus.if_valid); end
        next_sample();
        checks++; if (bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0 || bus.if_valid !== 1'b1) begin errors++; $display("FAIL mr_first got %b/%h/%h want 1/0/0", bus.if_valid, bus.if_pc, bus.if_instr); end
    endtask

    initial begin
        bus.id_ready = 1'b0;
        clear_redirects();
        test_reset();
        test_stream();
        test_fill_drain();
        test_branch();
        test_jr_priority();
        test_jump();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_queue_unit

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width (>=32).
REQ-002 SHALL have parameter QDEPTH, default 4, instruction queue entries (power of 2, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 imem_req  output  1  instruction read request this cycle.
REQ-007 imem_addr  output  XLEN  word-aligned read address.
REQ-008 imem_rdata  input  32  read data, valid exactly one cycle after imem_req.
REQ-009 if_valid  output  1  queue head holds an instruction.
REQ-010 if_instr  output  32  head instruction.
REQ-011 if_pc  output  XLEN  head instruction PC.
REQ-012 if_pc4  output  XLEN  if_pc + 4.
REQ-013 id_ready  input  1  decode accepts head this cycle.
REQ-014 redir_pc  input  XLEN  PC of redirecting instruction.
REQ-015 br_taken  input  1  taken conditional branch.
REQ-016 br_offset  input  XLEN  sign-extended branch immediate (words).
REQ-017 jump  input  1  absolute jump (J/JAL).
REQ-018 jump_index  input  26  jump instruction index field.
REQ-019 jr  input  1  register jump.
REQ-020 jr_target  input  XLEN  register jump target.
REQ-021 misalign  output  1  one-cycle pulse: jr_target[1:0] nonzero on accepted jr.

Function
REQ-022 Dequeue SHALL occur when if_valid && id_ready; head advances, count decrements.
REQ-023 imem_req SHALL assert when (count + inflight) < QDEPTH and no redirect this cycle; fetch PC advances by 4 on each request.
REQ-024 Response SHALL enqueue with the PC of its request in the cycle after imem_req (latency: request to if_valid = 2 cycles from empty).
REQ-025 Simultaneous enqueue and dequeue SHALL keep count unchanged; full queue with dequeue accepts the arriving response.
REQ-026 Redirect priority SHALL be jr > jump > br_taken (lower ones ignored when higher active).
REQ-027 Branch target SHALL be redir_pc + 4 + (br_offset << 2), modulo 2^XLEN.
REQ-028 Jump target SHALL be {(redir_pc+4)[XLEN-1:28], jump_index, 2'b00}.
REQ-029 JR target SHALL be jr_target with bits [1:0] forced to 0; misalign pulses if they were nonzero.
REQ-030 On any redirect: queue flushed (count=0, if_valid=0 next cycle), in-flight response discarded, fetch PC = target, first request to target next cycle.
REQ-031 Redirect in same cycle as dequeue SHALL still count the dequeue as taken by decode.
REQ-032 Pointers SHALL wrap modulo QDEPTH; no overflow or underflow under any input sequence.

Reset
REQ-033 While rst low: fetch PC=RESET_PC, count=0, pointers=0, inflight=0, if_valid=0, imem_req=0, misalign=0.
REQ-034 if_instr/if_pc SHALL read 0 while if_valid=0 after reset; first imem_req with imem_addr=RESET_PC in first cycle after rst release.
REQ-035 Reset mid-operation SHALL discard queue and in-flight data immediately.

Structure
REQ-036 Shared package SHALL hold the redirect-kind enum (NONE, BR, J, JR) and the PC increment constant 4.
REQ-037 Queue storage SHALL be a sub-module fetch_fifo (parametrised width XLEN+32, depth QDEPTH, flush input).

Verification
REQ-038 Release reset, id_ready=1, imem returns PC-as-data -> if_pc 0x0,0x4,0x8 on consecutive cycles after 2-cycle fill.
REQ-039 id_ready=0 for 10 cycles -> exactly QDEPTH (4) entries queued, imem_req low thereafter; id_ready=1 -> in-order drain 0x0..0xC.
REQ-040 br_taken, redir_pc=0x8, br_offset=3 -> queue flushed, next if_pc=0x18, stale response dropped.
REQ-041 jr, jump, br_taken same cycle, jr_target=0x103 -> fetch at 0x100, misalign pulses once.
REQ-042 jump, redir_pc=0x40000010, jump_index=0x10 -> next if_pc=0x40000040.
REQ-043 rst low with 3 entries queued and response in flight -> if_valid=0 at once; after release first request at RESET_PC.
